// File: rtl/mips_memory_writeback_stage.sv
// mips_memory_writeback_stage
//
// Pipeline register and load-alignment unit that sits between the memory
// datapath and the register-file writeback port. Each cycle it captures the
// memory word, ALU result, destination index and writeback controls. Before
// the register it extracts and extends sub-word loads and selects the
// writeback value. It then drives the register-file write port, plus a
// forwarding port for the execute stage.
//
// Optional feature: define MIPS_MEMORY_WRITEBACK_RETIRE_COUNT_EN to add the
// retired_count output. This is a wrapping 32-bit count of slots that
// retire from this stage.
//
// Ports
//   clock, reset_n    rising-edge clock; asynchronous active-low reset
//   in_valid          memory-stage slot holds a real instruction
//   mem_out           memory read word (already byte-masked)
//   alu_result        ALU result; bits [1:0] are the load byte offset
//   dest_reg          writeback register index
//   reg_write         instruction writes the register file
//   mem_to_reg        1 = write load data, 0 = write alu_result
//   access_size       0 word, 1 half, 2 byte, 3 reserved (treated as word)
//   sign_extend       1 = sign-extend sub-word loads, 0 = zero-extend
//   stall, flush      hazard-unit controls (flush wins over stall)
//   wb_valid          registered slot is valid
//   wb_we, wb_dest,
//   wb_data           register-file write port
//   wb_misaligned     registered slot was a misaligned load
//   fwd_valid, fwd_dest,
//   fwd_data          forwarding port (purely from registers)
//   retired_count     retire counter (only with the macro above)
//
// Only DATA_W = 32 is supported; the lane extraction is fixed to 32 bits.

module mips_memory_writeback_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 5
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] mem_out,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [REG_W-1:0]  dest_reg,
  input  logic              reg_write,
  input  logic              mem_to_reg,
  input  logic [1:0]        access_size,
  input  logic              sign_extend,
  input  logic              stall,
  input  logic              flush,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_W-1:0]  wb_dest,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_misaligned,
  output logic              fwd_valid,
  output logic [REG_W-1:0]  fwd_dest,
  output logic [DATA_W-1:0] fwd_data
`ifdef MIPS_MEMORY_WRITEBACK_RETIRE_COUNT_EN
  ,
  output logic [31:0]       retired_count
`endif
);

  localparam logic [1:0] SizeHalf = 2'd1;
  localparam logic [1:0] SizeByte = 2'd2;

  // ---------------------------------------------------------------------
  // Load alignment and writeback select (combinational, ahead of register)
  // ---------------------------------------------------------------------
  logic [1:0]        off;
  logic              is_half;
  logic              is_byte;
  logic              is_word;
  logic [15:0]       half_lane;
  logic [7:0]        byte_lane;
  logic [DATA_W-1:0] load_value;
  logic [DATA_W-1:0] wb_value;
  logic              misaligned;

  always_comb begin
    off       = alu_result[1:0];
    is_half   = (access_size == SizeHalf);
    is_byte   = (access_size == SizeByte);
    // Reserved encoding 3 falls through to word.
    is_word   = !is_half && !is_byte;

    // Little-endian lanes: half selected by off[1], byte by the full offset.
    half_lane = off[1] ? mem_out[31:16] : mem_out[15:0];
    case (off)
      2'd0:    byte_lane = mem_out[7:0];
      2'd1:    byte_lane = mem_out[15:8];
      2'd2:    byte_lane = mem_out[23:16];
      default: byte_lane = mem_out[31:24];
    endcase

    if (is_half) begin
      load_value = {{16{sign_extend & half_lane[15]}}, half_lane};
    end else if (is_byte) begin
      load_value = {{24{sign_extend & byte_lane[7]}}, byte_lane};
    end else begin
      load_value = mem_out;
    end

    wb_value   = mem_to_reg ? load_value : alu_result;

    // Byte loads can never be misaligned; non-load slots are never flagged.
    misaligned = mem_to_reg & in_valid &
                 ((is_half & off[0]) | (is_word & (off != 2'b00)));
  end

  // ---------------------------------------------------------------------
  // Stage register
  // ---------------------------------------------------------------------
  logic              valid_q;
  logic              reg_write_q;
  logic              misaligned_q;
  logic [REG_W-1:0]  dest_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      misaligned_q <= 1'b0;
      dest_q       <= '0;
      data_q       <= '0;
    end else if (flush) begin
      // Squash the slot. The data fields still load; valid_q = 0 keeps wb_we low.
      valid_q      <= 1'b0;
      misaligned_q <= 1'b0;
      reg_write_q  <= reg_write;
      dest_q       <= dest_reg;
      data_q       <= wb_value;
    end else if (!stall) begin
      valid_q      <= in_valid;
      misaligned_q <= misaligned;
      reg_write_q  <= reg_write;
      dest_q       <= dest_reg;
      data_q       <= wb_value;
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: all derived from the register, with no path from the inputs
  // ---------------------------------------------------------------------
  logic we;

  always_comb begin
    // Writes to $0 are always suppressed, as are misaligned slots.
    we            = valid_q & reg_write_q & ~misaligned_q & (dest_q != '0);
    wb_valid      = valid_q;
    wb_we         = we;
    wb_dest       = dest_q;
    wb_data       = data_q;
    wb_misaligned = misaligned_q;
    fwd_valid     = we;
    fwd_dest      = dest_q;
    fwd_data      = data_q;
  end

`ifdef MIPS_MEMORY_WRITEBACK_RETIRE_COUNT_EN
  // ---------------------------------------------------------------------
  // Retire counter: counts slots leaving the stage. Flush does not clear it.
  // ---------------------------------------------------------------------
  logic [31:0] retired_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retired_q <= '0;
    end else if (valid_q && !stall && !misaligned_q) begin
      retired_q <= retired_q + 32'd1;
    end
  end

  assign retired_count = retired_q;
`endif

endmodule

// File: tb/tb_mips_memory_writeback_stage.sv
module tb_mips_memory_writeback_stage;

  logic        clock;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] mem_out;
  logic [31:0] alu_result;
  logic [4:0]  dest_reg;
  logic        reg_write;
  logic        mem_to_reg;
  logic [1:0]  access_size;
  logic        sign_extend;
  logic        stall;
  logic        flush;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        wb_misaligned;
  logic        fwd_valid;
  logic [4:0]  fwd_dest;
  logic [31:0] fwd_data;
`ifdef MIPS_MEMORY_WRITEBACK_RETIRE_COUNT_EN
  logic [31:0] retired_count;
`endif

  int total = 0;
  int bad   = 0;

  mips_memory_writeback_stage #(
    .DATA_W(32),
    .REG_W (5)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .in_valid     (in_valid),
    .mem_out      (mem_out),
    .alu_result   (alu_result),
    .dest_reg     (dest_reg),
    .reg_write    (reg_write),
    .mem_to_reg   (mem_to_reg),
    .access_size  (access_size),
    .sign_extend  (sign_extend),
    .stall        (stall),
    .flush        (flush),
    .wb_valid     (wb_valid),
    .wb_we        (wb_we),
    .wb_dest      (wb_dest),
    .wb_data      (wb_data),
    .wb_misaligned(wb_misaligned),
    .fwd_valid    (fwd_valid),
    .fwd_dest     (fwd_dest),
    .fwd_data     (fwd_data)
`ifdef MIPS_MEMORY_WRITEBACK_RETIRE_COUNT_EN
    ,
    .retired_count(retired_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic        v;
    logic [31:0] mem;
    logic [31:0] alu;
    logic [4:0]  dst;
    logic        rw;
    logic        m2r;
    logic [1:0]  sz;
    logic        sx;
    logic        e_valid;
    logic        e_we;
    logic [31:0] e_data;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic we,
                           input logic [4:0] dst, input logic [31:0] data, input logic mis);
    check({tag, ".wb_valid"},      {31'd0, wb_valid},      {31'd0, v});
    check({tag, ".wb_we"},         {31'd0, wb_we},         {31'd0, we});
    check({tag, ".wb_dest"},       {27'd0, wb_dest},       {27'd0, dst});
    check({tag, ".wb_data"},       wb_data,                data);
    check({tag, ".wb_misaligned"}, {31'd0, wb_misaligned}, {31'd0, mis});
    check({tag, ".fwd_valid"},     {31'd0, fwd_valid},     {31'd0, we});
    check({tag, ".fwd_dest"},      {27'd0, fwd_dest},      {27'd0, dst});
    check({tag, ".fwd_data"},      fwd_data,               data);
  endtask

  task automatic drive(input logic v, input logic [31:0] mem, input logic [31:0] alu,
                       input logic [4:0] dst, input logic rw, input logic m2r,
                       input logic [1:0] sz, input logic sx);
    in_valid    = v;
    mem_out     = mem;
    alu_result  = alu;
    dest_reg    = dst;
    reg_write   = rw;
    mem_to_reg  = m2r;
    access_size = sz;
    sign_extend = sx;
  endtask

  // Outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    //           name          v  mem           alu           dst rw m2r sz sx  ev ewe edata         emis
    vecs.push_back('{"byte_sx",    1, 32'h00800000, 32'h00000012, 8,  1, 1, 2, 1, 1, 1, 32'hFFFFFF80, 0});
    vecs.push_back('{"byte_zx",    1, 32'h00800000, 32'h00000012, 8,  1, 1, 2, 0, 1, 1, 32'h00000080, 0});
    vecs.push_back('{"half_sx",    1, 32'hBEEF0000, 32'h00000002, 9,  1, 1, 1, 1, 1, 1, 32'hFFFFBEEF, 0});
    vecs.push_back('{"half_mis",   1, 32'hBEEF0000, 32'h00000003, 9,  1, 1, 1, 1, 1, 0, 32'hFFFFBEEF, 1});
    vecs.push_back('{"alu_r0",     1, 32'h0,        32'h00001234, 0,  1, 0, 0, 0, 1, 0, 32'h00001234, 0});
    vecs.push_back('{"word",       1, 32'hCAFEBABE, 32'h00000100, 31, 1, 1, 0, 1, 1, 1, 32'hCAFEBABE, 0});
    vecs.push_back('{"word_mis",   1, 32'hCAFEBABE, 32'h00000101, 31, 1, 1, 0, 1, 1, 0, 32'hCAFEBABE, 1});
    vecs.push_back('{"rsvd_word",  1, 32'h11223344, 32'h00000104, 3,  1, 1, 3, 1, 1, 1, 32'h11223344, 0});
    vecs.push_back('{"rsvd_mis",   1, 32'h11223344, 32'h00000106, 3,  1, 1, 3, 1, 1, 0, 32'h11223344, 1});
    vecs.push_back('{"byte3_zx",   1, 32'hA5000000, 32'h00000003, 4,  1, 1, 2, 0, 1, 1, 32'h000000A5, 0});
    vecs.push_back('{"byte3_sx",   1, 32'hA5000000, 32'h00000003, 4,  1, 1, 2, 1, 1, 1, 32'hFFFFFFA5, 0});
    vecs.push_back('{"byte0_pos",  1, 32'h0000007F, 32'h00000000, 6,  1, 1, 2, 1, 1, 1, 32'h0000007F, 0});
    vecs.push_back('{"byte1_zx",   1, 32'h0000AB00, 32'h00000001, 6,  1, 1, 2, 0, 1, 1, 32'h000000AB, 0});
    vecs.push_back('{"half0_zx",   1, 32'h00008001, 32'h00000000, 2,  1, 1, 1, 0, 1, 1, 32'h00008001, 0});
    vecs.push_back('{"half0_sx",   1, 32'h00008001, 32'h00000000, 2,  1, 1, 1, 1, 1, 1, 32'hFFFF8001, 0});
    vecs.push_back('{"inval_mis",  0, 32'h00000000, 32'h00000001, 2,  1, 1, 1, 1, 0, 0, 32'h00000000, 0});
    vecs.push_back('{"no_rw",      1, 32'h0,        32'h0000DEAD, 5,  0, 0, 0, 0, 1, 0, 32'h0000DEAD, 0});
    vecs.push_back('{"alu_unal",   1, 32'hFFFFFFFF, 32'h00000003, 7,  1, 0, 0, 1, 1, 1, 32'h00000003, 0});

    reset_n = 1'b0;
    stall   = 1'b0;
    flush   = 1'b0;
    drive(1, 32'hFFFFFFFF, 32'h3, 5'd9, 1, 1, 1, 1);
    step();
    step();
    check_out("reset_hold", 0, 0, 5'd0, 32'h0, 0);
    #2 reset_n = 1'b1;

    // Table-driven single-cycle vectors.
    foreach (vecs[i]) begin
      drive(vecs[i].v, vecs[i].mem, vecs[i].alu, vecs[i].dst, vecs[i].rw, vecs[i].m2r,
            vecs[i].sz, vecs[i].sx);
      step();
      check_out(vecs[i].name, vecs[i].e_valid, vecs[i].e_we, vecs[i].dst, vecs[i].e_data,
                vecs[i].e_mis);
    end

    // Asynchronous reset mid-stream: outputs clear with no clock edge.
    drive(1, 32'h00800000, 32'h12, 5'd8, 1, 1, 2, 1);
    step();
    check_out("pre_async", 1, 1, 5'd8, 32'hFFFFFF80, 0);
    #2 reset_n = 1'b0;
    #1 check_out("async_rst", 0, 0, 5'd0, 32'h0, 0);
    #3 reset_n = 1'b1;

    // Stall: slot A held for three cycles while slot B is presented.
    step();
    check_out("after_rst", 1, 1, 5'd8, 32'hFFFFFF80, 0);
    drive(1, 32'h0, 32'h5555, 5'd10, 1, 0, 0, 0);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check_out($sformatf("stall%0d", k), 1, 1, 5'd8, 32'hFFFFFF80, 0);
    end
    flush = 1'b1;
    step();
    check({"flush_stall", ".wb_valid"}, {31'd0, wb_valid}, 32'd0);
    check({"flush_stall", ".wb_we"},    {31'd0, wb_we},    32'd0);
    check({"flush_stall", ".fwd_valid"}, {31'd0, fwd_valid}, 32'd0);
    stall = 1'b0;
    flush = 1'b0;
    step();
    check_out("slot_b", 1, 1, 5'd10, 32'h5555, 0);

    // Flush clears a pending misaligned flag.
    drive(1, 32'hBEEF0000, 32'h3, 5'd9, 1, 1, 1, 1);
    step();
    check({"mis_set", ".wb_misaligned"}, {31'd0, wb_misaligned}, 32'd1);
    flush = 1'b1;
    step();
    check({"mis_flush", ".wb_misaligned"}, {31'd0, wb_misaligned}, 32'd0);
    check({"mis_flush", ".wb_valid"},      {31'd0, wb_valid},      32'd0);
    flush = 1'b0;

`ifdef MIPS_MEMORY_WRITEBACK_RETIRE_COUNT_EN
    #2 reset_n = 1'b0;
    #1 check("cnt_reset", retired_count, 32'd0);
    #2 reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(1, 32'h0, 32'h100 + k, 5'd11, 1, 0, 0, 0);
      step();
      if (k == 2) begin
        stall = 1'b1;
        step();
        step();
        stall = 1'b0;
      end
    end
    drive(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
    step();
    step();
    check("cnt_five", retired_count, 32'd5);
    force dut.retired_q = 32'hFFFFFFFF;
    #1 release dut.retired_q;
    drive(1, 32'h0, 32'h7, 5'd12, 1, 0, 0, 0);
    step();
    check("cnt_pre_wrap", retired_count, 32'hFFFFFFFF);
    drive(0, 32'h0, 32'h0, 5'd0, 0, 0, 0, 0);
    step();
    check("cnt_wrap", retired_count, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_memory_writeback_stage.md
Name: mips_memory_writeback_stage

Overview:
Pipeline register and load-alignment unit between the memory datapath and the register-file writeback. It captures the memory word (already byte-masked), ALU result, destination register and writeback controls each cycle. It extracts and extends sub-word loads, selects the writeback value, and drives the register-file write port plus a forwarding port for the execute stage. It honours stall and flush from the hazard unit.

Parameters:
- DATA_W, 32, datapath word width; only 32 is supported.
- REG_W, 5, register index width.

Ports:
- clock  input  1  pipeline clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  memory-stage slot holds a real instruction.
- mem_out  input  32  memory read word, masked per access size.
- alu_result  input  32  ALU result; bits [1:0] are the load address offset.
- dest_reg  input  5  writeback register index.
- reg_write  input  1  instruction writes the register file.
- mem_to_reg  input  1  1 = writeback value is load data, 0 = alu_result.
- access_size  input  2  0 = word, 1 = half, 2 = byte; 3 is reserved and treated as word.
- sign_extend  input  1  1 = sign-extend sub-word loads, 0 = zero-extend.
- stall  input  1  hold the stage register.
- flush  input  1  squash the incoming slot.
- wb_valid  output  1  registered slot is valid.
- wb_we  output  1  register-file write enable.
- wb_dest  output  5  register-file write index.
- wb_data  output  32  register-file write data.
- wb_misaligned  output  1  registered slot was a misaligned load.
- fwd_valid  output  1  forwarding hit is possible; equals wb_we.
- fwd_dest  output  5  forwarding register index.
- fwd_data  output  32  forwarding value; equals wb_data.

Behaviour:
- Reset (reset_n=0, asynchronous): wb_valid=0, wb_dest=0, wb_data=0, wb_misaligned=0. All derived outputs are 0. Reset has priority over stall and flush, and takes effect mid-operation with no pending state kept.
- Latency: one cycle from the inputs to the wb_* outputs. Alignment and extension are computed combinationally before the register.
- Priority on each rising edge, highest first: flush, then stall, then load.
  - flush=1: wb_valid <- 0, wb_misaligned <- 0. The data fields may load, but wb_we is 0.
  - stall=1, flush=0: all registers hold their values. wb_we stays asserted if it was asserted, so a writeback is idempotent over repeated stall cycles.
  - Otherwise: register the computed values, with wb_valid <- in_valid.
- Load extraction is little-endian, with off = alu_result[1:0]:
  - Word: value = mem_out.
  - Half: lane = mem_out >> (16*off[1]); take bits [15:0], then extend.
  - Byte: lane = mem_out >> (8*off); take bits [7:0], then extend.
  - Extension: sign_extend=1 replicates the top lane bit; sign_extend=0 fills with zeros.
- Writeback value = mem_to_reg ? extracted value : alu_result.
- Misaligned load = mem_to_reg & in_valid & ((half & off[0]) | (word & off!=0)). The flag is registered into wb_misaligned. A misaligned slot never writes.
- wb_we = wb_valid & registered reg_write & ~wb_misaligned & (wb_dest != 0). A write to $0 is always suppressed.
- Forwarding outputs are taken from the registers only, with no combinational path from the inputs.

Optional Feature:
- Macro: MIPS_MEMORY_WRITEBACK_RETIRE_COUNT_EN.
- When defined: adds the output retired_count [31:0], a counter.
  - Reset value 0.
  - Increments on each rising edge where wb_valid=1, stall=0 and wb_misaligned=0.
  - Wraps from 0xFFFFFFFF to 0.
  - Flush does not clear it.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Test Plan:
- Reset: drive reset_n=0 mid-stream with wb_valid=1 -> all outputs are 0 immediately, with no clock edge needed.
- Byte load: mem_out=0x00800000, alu_result=0x12, byte, sign_extend=1, dest=8 -> next cycle wb_we=1, wb_dest=8, wb_data=0xFFFFFF80. With sign_extend=0 -> wb_data=0x00000080.
- Half load: mem_out=0xBEEF0000, alu_result=0x2, half, sign_extend=1 -> wb_data=0xFFFFBEEF. With alu_result=0x3 -> wb_misaligned=1 and wb_we=0.
- ALU writeback to $0: mem_to_reg=0, alu_result=0x1234, dest=0 -> wb_valid=1, wb_we=0, fwd_valid=0.
- Stall and flush: load slot A, then hold stall=1 for 3 cycles while presenting slot B -> outputs stay on A. Then apply flush=1 with stall=1 -> wb_valid=0 next cycle.
- Counter (macro defined): issue 5 valid non-misaligned slots, one of which is stalled for 2 cycles -> retired_count=5. Preload the counter to 0xFFFFFFFF by forcing it, then retire one slot -> retired_count=0.
